// File: rtl/mac_row_ws_os_if.sv
// Bus bundle for one MAC row: west/north inputs, south/east outputs.
interface mac_row_ws_os_if #(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int col     = 8
);
  logic                     mode;
  logic [bw-1:0]            in_w;
  logic [2:0]               inst_w;
  logic [psum_bw*col-1:0]   in_n;
  logic [psum_bw*col-1:0]   out_s;
  logic [col-1:0]           valid;
  logic [bw-1:0]            out_e;
  logic [2:0]               inst_e;
  logic                     busy;

  modport master (
    output mode, in_w, inst_w, in_n,
    input  out_s, valid, out_e, inst_e, busy
  );

  modport slave (
    input  mode, in_w, inst_w, in_n,
    output out_s, valid, out_e, inst_e, busy
  );
endinterface

// File: rtl/mac_row_ws_os.sv
// One row of MAC columns, switchable between weight-stationary and
// output-stationary dataflow; activations and instructions ripple west to east.
module mac_row_ws_os #(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int col     = 8
) (
  input  logic          clk,
  input  logic          reset,
  mac_row_ws_os_if.slave bus
);

  typedef enum logic {MODE_WS = 1'b0, MODE_OS = 1'b1} mode_e;

  mode_e mode_q, mode_d;
  logic  mode_change;

  logic        [bw-1:0]      a_q     [col];
  logic        [2:0]         i_q     [col];
  logic signed [bw-1:0]      w_q     [col];
  logic        [psum_bw-1:0] acc_q   [col];
  logic        [psum_bw-1:0] out_q   [col];
  logic        [col-1:0]     loaded;
  logic        [col-1:0]     valid_q;

  logic        [bw-1:0]      a_west  [col];
  logic        [2:0]         i_west  [col];
  logic        [2:0]         i_pri   [col];
  logic        [2:0]         i_next  [col];
  logic signed [bw-1:0]      w_sel   [col];
  logic signed [psum_bw-1:0] prod    [col];
  logic        [psum_bw-1:0] base    [col];
  logic        [psum_bw-1:0] sum     [col];
  logic        [col-1:0]     do_load, do_exec, do_drain, do_capture;
  logic                      busy_w;

  // Dataflow mode: only re-sampled when the row is completely idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) mode_q <= MODE_WS;
    else        mode_q <= mode_d;
  end

  always_comb begin
    mode_d = mode_q;
    if (!busy_w && (bus.inst_w == '0)) mode_d = mode_e'(bus.mode);
  end

  always_comb begin
    mode_change = (mode_d != mode_q);
  end

  always_comb begin
    busy_w = 1'b0;
    for (int unsigned c = 0; c < col; c++) busy_w = busy_w | (|i_q[c]);
  end

  always_comb begin
    a_west[0] = bus.in_w;
    i_west[0] = bus.inst_w;
    for (int unsigned c = 1; c < col; c++) begin
      a_west[c] = a_q[c-1];
      i_west[c] = i_q[c-1];
    end
  end

  // Priority first, then mode filtering: a drain in WS swallows its execute bit.
  always_comb begin
    for (int unsigned c = 0; c < col; c++) begin
      if      (i_west[c][2]) i_pri[c] = 3'b100;
      else if (i_west[c][1]) i_pri[c] = 3'b010;
      else if (i_west[c][0]) i_pri[c] = 3'b001;
      else                   i_pri[c] = 3'b000;

      do_drain[c]   = i_pri[c][2] && (mode_q == MODE_OS);
      do_exec[c]    = i_pri[c][1];
      do_load[c]    = i_pri[c][0] && (mode_q == MODE_WS);
      do_capture[c] = do_load[c] && !loaded[c];

      i_next[c] = 3'b000;
      if (do_drain[c])               i_next[c] = 3'b100;
      if (do_exec[c])                i_next[c] = 3'b010;
      if (do_load[c] && loaded[c])   i_next[c] = 3'b001;

      w_sel[c] = (mode_q == MODE_WS) ? w_q[c] : bus.in_n[c*psum_bw +: bw];
      prod[c]  = psum_bw'($signed({1'b0, a_west[c]})) * psum_bw'(w_sel[c]);
      base[c]  = (mode_q == MODE_WS) ? bus.in_n[c*psum_bw +: psum_bw] : acc_q[c];
      sum[c]   = base[c] + prod[c];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned c = 0; c < col; c++) begin
        a_q[c]   <= '0;
        i_q[c]   <= '0;
        w_q[c]   <= '0;
        acc_q[c] <= '0;
        out_q[c] <= '0;
      end
      loaded  <= '0;
      valid_q <= '0;
    end else begin
      for (int unsigned c = 0; c < col; c++) begin
        a_q[c]     <= a_west[c];
        i_q[c]     <= i_next[c];
        valid_q[c] <= (do_exec[c] && (mode_q == MODE_WS)) || do_drain[c];
        if (do_capture[c]) begin
          w_q[c]    <= a_west[c];
          loaded[c] <= 1'b1;
        end
        if (do_exec[c] && (mode_q == MODE_WS)) out_q[c] <= sum[c];
        if (do_exec[c] && (mode_q == MODE_OS)) acc_q[c] <= sum[c];
        if (do_drain[c]) begin
          out_q[c] <= acc_q[c];
          acc_q[c] <= '0;
        end
        // A mode switch only happens with nothing in flight, so this cannot race a drain.
        if (mode_change) begin
          loaded[c] <= 1'b0;
          acc_q[c]  <= '0;
        end
      end
    end
  end

  always_comb begin
    bus.out_s = '0;
    for (int unsigned c = 0; c < col; c++) bus.out_s[c*psum_bw +: psum_bw] = out_q[c];
    bus.valid  = valid_q;
    bus.out_e  = a_q[col-1];
    bus.inst_e = i_q[col-1];
    bus.busy   = busy_w;
  end

endmodule

// File: doc/mac_row_ws_os.md
MAC_ROW_WS_OS -- requirements
Module: mac_row_ws_os

Interface
REQ-001 The block SHALL have parameter bw, default 4, meaning operand width (activation unsigned, weight signed two's-complement).
REQ-002 The block SHALL have parameter psum_bw, default 16, meaning partial-sum/accumulator width; legal only if psum_bw >= 2*bw+1.
REQ-003 The block SHALL have parameter col, default 8, meaning number of MAC columns.
REQ-004 The block SHALL have port clk  in  1  clock; all state on rising edge.
REQ-005 The block SHALL have port reset  in  1  asynchronous active-low reset (0 = reset).
REQ-006 The block SHALL have port mode  in  1  requested dataflow: 0 = weight-stationary (WS), 1 = output-stationary (OS).
REQ-007 The block SHALL have port in_w  in  bw  west activation or weight-load data.
REQ-008 The block SHALL have port inst_w  in  3  instruction: [0] kernel load, [1] execute, [2] drain.
REQ-009 The block SHALL have port in_n  in  psum_bw*col  per-column north input (WS: incoming psum; OS: weight in low bw bits, signed).
REQ-010 The block SHALL have port out_s  out  psum_bw*col  per-column south output.
REQ-011 The block SHALL have port valid  out  col  per-column out_s qualifier.
REQ-012 The block SHALL have port out_e  out  bw  activation leaving last column (chaining).
REQ-013 The block SHALL have port inst_e  out  3  instruction leaving last column.
REQ-014 The block SHALL have port busy  out  1  any column pipeline register holds a nonzero instruction.

Function
REQ-015 Each column c SHALL register a_q (bw) and i_q (3) from its west input every cycle; column c+1 sees column c's a_q/i_q; column 0 sees in_w/inst_w; out_e/inst_e = last column's a_q/i_q.
REQ-016 The effective mode SHALL be register mode_q, loaded from mode only in cycles where busy=0 and inst_w=0; otherwise held.
REQ-017 Priority per column SHALL be drain > execute > load; lower-priority bits SHALL be cleared before registering i_q.
REQ-018 Load (WS only): a column with loaded=0 SHALL capture w_q <= west data, set loaded=1, and forward i_q[0]=0; a column with loaded=1 SHALL forward the load bit east; col consecutive load cycles thus place the k-th value in column k.
REQ-019 Execute in WS SHALL register psum_c <= in_n_c + sext(a*w_q) (a zero-extended, w_q signed), assert valid[c] one cycle later for one cycle, out_s_c = psum_c.
REQ-020 Execute in OS SHALL register acc_c <= acc_c + sext(a*in_n_c[bw-1:0]); valid[c] SHALL stay 0.
REQ-021 Drain in OS SHALL register out_s_c <= acc_c, clear acc_c to 0 in the same edge, and assert valid[c] for one cycle; execute and drain in the same cycle SHALL resolve to drain only.
REQ-022 Load in OS and drain in WS SHALL be dropped (not forwarded, no state change).
REQ-023 All sums SHALL wrap modulo 2^psum_bw; no saturation, no overflow flag.
REQ-024 Latency SHALL be c+1 cycles from inst_w sampled at column 0 to valid[c] asserted.
REQ-025 out_s_c SHALL hold its last value while valid[c]=0.
REQ-026 A new mode_q SHALL clear all loaded flags and all acc_c in the same edge as it changes.

Reset
REQ-027 While reset=0, all a_q, i_q, w_q, loaded, acc_c, psum_c, out_s, valid, out_e, inst_e, busy SHALL be 0 and mode_q SHALL be 0 (WS), immediately and independent of clk.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight instructions; the first edge after release SHALL behave as from power-up.

Verification
REQ-029 Reset: assert reset=0 during an 8-column execute wave -> out_s=0, valid=0, busy=0 same cycle; after release a load must reach column 0 first.
REQ-030 WS: load weights -4,-3,...,3 over 8 cycles, then execute a=5, in_n=0 -> valid[c] at c+1 cycles after issue, out_s_c = 5*(c-4) (-20..15).
REQ-031 OS: mode=1, three executes a=15, in_n weights all -8 -> then drain: out_s_c = -360 per column, valid[c] one cycle each, staggered; a second drain yields 0.
REQ-032 Wrap: OS, 700 executes a=15, w=7 (psum_bw=16), drain -> out_s_c = 7964 (73500 mod 65536).
REQ-033 Mode guard: toggle mode while busy=1 -> mode_q unchanged, results match old mode; mode_q updates first idle cycle and loaded flags/acc clear.
REQ-034 Priority: OS, inst_w=3'b110 -> drain only, accumulator not incremented that cycle; inst_e shows 3'b100 col cycles later.
